countdown_timer: RTL

- Loadable minutes:seconds countdown timer: the down-counting counterpart of the team's mod-60 up-counter.
- Counts a preset MM:SS value down to 00:00 at one step per prescaled second.
- Signals expiry with a one-cycle pulse and a sticky level.
- Sits beside the clock/stopwatch counters and feeds the same display and alarm logic.

---
 rtl/countdown_timer.sv | 97 +++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Loadable MM:SS countdown timer stepping once per TICK_DIV clocks.
// Emits a one-cycle done pulse and a sticky expired level on reaching 00:00.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] PRESC_LAST = CW'(TICK_DIV - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] PAUSED  = 2'd2;
  localparam logic [1:0] EXPIRED = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] presc;

  function automatic logic [5:0] clamp59(input logic [5:0] v);
    return (v > 6'd59) ? 6'd59 : v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      presc   <= '0;
      min     <= '0;
      sec     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        min     <= clamp59(load_min);
        sec     <= clamp59(load_sec);
        presc   <= '0;
        state   <= IDLE;
        running <= 1'b0;
        expired <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!pause && start && (min != '0 || sec != '0)) begin
              state   <= RUN;
              presc   <= '0;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end else if (presc == PRESC_LAST) begin
              presc <= '0;
              // Only 00:01 can step to 00:00; a borrow always lands on xx:59.
              if (sec != '0) begin
                sec <= sec - 6'd1;
                if (min == '0 && sec == 6'd1) begin
                  state   <= EXPIRED;
                  running <= 1'b0;
                  expired <= 1'b1;
                  done    <= 1'b1;
                end
              end else begin
                min <= min - 6'd1;
                sec <= 6'd59;
              end
            end else begin
              presc <= presc + CW'(1);
            end
          end
          PAUSED: begin
            if (start && !pause) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
